k12a_sevenseg_capture: RTL and testbench



---
 rtl/k12a_sevenseg_capture.sv | 143 ++++++++++++++
 tb/tb_k12a_sevenseg_capture.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k12a_sevenseg_capture.sv
// Recovers hex nibbles from a multiplexed seven-segment bus and emits whole frames on valid/ready.
// Optional: define K12A_SEVENSEG_CAPTURE_BLANK_EN to accept all-off as a blank digit and add the blank output.
module k12a_sevenseg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   invalid,
`ifdef K12A_SEVENSEG_CAPTURE_BLANK_EN
    output logic [NUM_DIGITS-1:0]   blank,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    typedef logic [7:0] cnt_t;
    localparam cnt_t STABLE = cnt_t'(STABLE_CYCLES);

    typedef struct packed {
        logic [3:0] nib;
        logic       inv;
`ifdef K12A_SEVENSEG_CAPTURE_BLANK_EN
        logic       blk;
`endif
    } dec_t;

    function automatic dec_t decode(input logic [6:0] pat);
        dec_t d;
        d     = '0;
        d.inv = 1'b0;
        case (pat)
            7'h7E: d.nib = 4'h0;
            7'h30: d.nib = 4'h1;
            7'h6D: d.nib = 4'h2;
            7'h79: d.nib = 4'h3;
            7'h33: d.nib = 4'h4;
            7'h5B: d.nib = 4'h5;
            7'h5F: d.nib = 4'h6;
            7'h70: d.nib = 4'h7;
            7'h7F: d.nib = 4'h8;
            7'h7B: d.nib = 4'h9;
            7'h77: d.nib = 4'hA;
            7'h1F: d.nib = 4'hB;
            7'h4E: d.nib = 4'hC;
            7'h3D: d.nib = 4'hD;
            7'h4F: d.nib = 4'hE;
            7'h47: d.nib = 4'hF;
`ifdef K12A_SEVENSEG_CAPTURE_BLANK_EN
            7'h00: d.blk = 1'b1;
`endif
            default: d.inv = 1'b1;
        endcase
        return d;
    endfunction

    logic [6:0]              seg_s, seg_p;
    logic [NUM_DIGITS-1:0]   sel_s, sel_p;
    cnt_t                    cnt, cnt_next;
    logic [NUM_DIGITS-1:0]   mask, mask_next;
    logic [4*NUM_DIGITS-1:0] shadow_nib;
    logic [NUM_DIGITS-1:0]   shadow_inv;
`ifdef K12A_SEVENSEG_CAPTURE_BLANK_EN
    logic [NUM_DIGITS-1:0]   shadow_blk;
`endif
    logic                    one_hot, accept, frame_full, commit, drop;
    dec_t                    dec;

    // NOTE: every signal gets its default first so no path through this block can infer a latch.
    always_comb begin
        one_hot  = (sel_s != '0) && ((sel_s & (sel_s - NUM_DIGITS'(1))) == '0);
        cnt_next = cnt;
        if (!one_hot)
            cnt_next = '0;
        else if ({seg_s, sel_s} != {seg_p, sel_p})
            cnt_next = cnt_t'(1);
        else if (cnt < STABLE)
            cnt_next = cnt + cnt_t'(1);
        // Only the transition into saturation accepts, so a long dwell captures once.
        accept     = one_hot && (cnt_next == STABLE) && (cnt != STABLE);
        frame_full = &mask;
        commit     = frame_full && (!out_valid || out_ready);
        drop       = frame_full && out_valid && !out_ready;
        mask_next  = (frame_full ? '0 : mask) | (accept ? sel_s : '0);
        dec        = decode(seg_s);
    end

    // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            seg_s     <= '0;
            sel_s     <= '0;
            seg_p     <= '0;
            sel_p     <= '0;
            cnt       <= '0;
            mask      <= '0;
            value     <= '0;
            invalid   <= '0;
`ifdef K12A_SEVENSEG_CAPTURE_BLANK_EN
            blank     <= '0;
`endif
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            seg_s <= seg_in;
            sel_s <= digit_sel;
            seg_p <= seg_s;
            sel_p <= sel_s;
            cnt   <= cnt_next;
            mask  <= mask_next;
            if (commit) begin
                value     <= shadow_nib;
                invalid   <= shadow_inv;
`ifdef K12A_SEVENSEG_CAPTURE_BLANK_EN
                blank     <= shadow_blk;
`endif
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop)
                overrun <= 1'b1;
        end
    end

    // NOTE: shadow storage has no reset; a commit needs a full mask, so only freshly written digits reach value.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (accept && sel_s[i]) begin
                shadow_nib[4*i +: 4] <= dec.nib;
                shadow_inv[i]        <= dec.inv;
`ifdef K12A_SEVENSEG_CAPTURE_BLANK_EN
                shadow_blk[i]        <= dec.blk;
`endif
            end
        end
    end

endmodule

// File: tb/tb_k12a_sevenseg_capture.sv
// Randomized and directed bench for k12a_sevenseg_capture against a dwell-level reference model.
// Honours K12A_SEVENSEG_CAPTURE_BLANK_EN when defined.
module tb_k12a_sevenseg_capture;
    localparam int N = 4;
    localparam int S = 4;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [6:0]     seg_in;
    logic [N-1:0]   digit_sel;
    logic [4*N-1:0] value;
    logic [N-1:0]   invalid;
    logic [N-1:0]   blank;
    logic           out_valid;
    logic           out_ready;
    logic           overrun;

    k12a_sevenseg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .seg_in    (seg_in),
        .digit_sel (digit_sel),
        .value     (value),
        .invalid   (invalid),
`ifdef K12A_SEVENSEG_CAPTURE_BLANK_EN
        .blank     (blank),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

`ifndef K12A_SEVENSEG_CAPTURE_BLANK_EN
    assign blank = '0;
`endif

    always #5 clock = ~clock;

    typedef struct {
        logic [4*N-1:0] val;
        logic [N-1:0]   inv;
        logic [N-1:0]   blk;
    } frame_t;

    int             vectors = 0;
    int             miscompares = 0;
    int             frames_seen = 0;
    bit             mon_en = 1'b1;
    frame_t         exp_q[$];
    logic [4*N-1:0] last_val;
    logic [N-1:0]   last_inv;
    logic [N-1:0]   last_blk;

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference model: per-digit captured nibble/flags plus which digits this frame already holds.
    logic [3:0] m_nib [N];
    bit         m_inv [N];
    bit         m_blk [N];
    bit         m_cap [N];

    function automatic void model_clear();
        for (int k = 0; k < N; k++) m_cap[k] = 1'b0;
        exp_q.delete();
    endfunction

    // A dwell is a run of identical input cycles; it is captured when its select is one-hot and it lasts S cycles.
    task automatic dwell(input logic [6:0] seg, input logic [N-1:0] sel, input int dur);
        if ($countones(sel) == 1 && dur >= S) begin
            for (int k = 0; k < N; k++) begin
                if (sel[k]) begin
                    m_nib[k] = 4'h0;
                    m_inv[k] = 1'b1;
                    m_blk[k] = 1'b0;
                    for (int t = 0; t < 16; t++)
                        if (seg_tab[t] == seg) begin m_nib[k] = 4'(t); m_inv[k] = 1'b0; end
`ifdef K12A_SEVENSEG_CAPTURE_BLANK_EN
                    if (seg == 7'h00) begin m_inv[k] = 1'b0; m_blk[k] = 1'b1; end
`endif
                    m_cap[k] = 1'b1;
                end
            end
            if (m_cap.sum() with (int'(item)) == N) begin
                frame_t f;
                for (int k = 0; k < N; k++) begin
                    f.val[4*k +: 4] = m_nib[k];
                    f.inv[k]        = m_inv[k];
                    f.blk[k]        = m_blk[k];
                    m_cap[k]        = 1'b0;
                end
                exp_q.push_back(f);
            end
        end
        seg_in    = seg;
        digit_sel = sel;
        repeat (dur) @(negedge clock);
    endtask

    task automatic scan(input logic [15:0] hex, input int dur);
        for (int k = 0; k < N; k++) dwell(seg_tab[hex[4*k +: 4]], N'(1) << k, dur);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        seg_in    = '0;
        digit_sel = '0;
        @(negedge clock);
        reset_n   = 1'b1;
        model_clear();
    endtask

    always @(negedge clock) begin
        if (mon_en && reset_n && out_valid && out_ready) begin
            frames_seen++;
            vectors++;
            last_val = value;
            last_inv = invalid;
            last_blk = blank;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL extra_frame: value=%h invalid=%b, no frame required", value, invalid);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
`ifdef K12A_SEVENSEG_CAPTURE_BLANK_EN
                if (value !== f.val || invalid !== f.inv || blank !== f.blk) begin
`else
                if (value !== f.val || invalid !== f.inv) begin
`endif
                    miscompares++;
                    $display("FAIL frame: value=%h invalid=%b blank=%b, required %h %b %b",
                             value, invalid, blank, f.val, f.inv, f.blk);
                end
            end
        end
    end

    task automatic test_reset();
        reset_n   = 1'b0;
        out_ready = 1'b1;
        seg_in    = '0;
        digit_sel = '0;
        repeat (2) @(negedge clock);
        vectors++;
        if (value !== '0 || invalid !== '0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: value=%h invalid=%b out_valid=%b overrun=%b, required all 0",
                     value, invalid, out_valid, overrun);
        end
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic test_basic();
        int seen0;
        seen0 = frames_seen;
        scan(16'h3210, 6);
        dwell(7'h00, '0, 10);
        vectors++;
        if (frames_seen - seen0 !== 1 || last_val !== 16'h3210 || last_inv !== 4'b0000 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic: frames=%0d value=%h invalid=%b, required 1 3210 0000",
                     frames_seen - seen0, last_val, last_inv);
        end
    endtask

    task automatic test_short_dwell();
        int seen0;
        do_reset();
        seen0 = frames_seen;
        dwell(7'h7E, 4'b0001, S - 1);
        dwell(7'h30, 4'b0010, 6);
        dwell(7'h6D, 4'b0100, 6);
        dwell(7'h79, 4'b1000, 6);
        dwell(7'h00, '0, 10);
        vectors++;
        if (frames_seen !== seen0) begin
            miscompares++;
            $display("FAIL short_dwell: frames=%0d, required 0", frames_seen - seen0);
        end
        dwell(7'h7E, 4'b0001, S);
        dwell(7'h00, '0, 10);
        vectors++;
        if (frames_seen - seen0 !== 1 || last_val !== 16'h3210 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL short_dwell_recover: frames=%0d value=%h, required 1 3210",
                     frames_seen - seen0, last_val);
        end
    endtask

    task automatic test_invalid();
        logic [6:0] bad;
`ifdef K12A_SEVENSEG_CAPTURE_BLANK_EN
        bad = 7'h00;
`else
        bad = 7'h01;
`endif
        do_reset();
        dwell(7'h7E, 4'b0001, 6);
        dwell(7'h30, 4'b0010, 6);
        dwell(bad,   4'b0100, 6);
        dwell(7'h79, 4'b1000, 6);
        dwell(7'h00, '0, 10);
        vectors++;
`ifdef K12A_SEVENSEG_CAPTURE_BLANK_EN
        if (last_val !== 16'h3010 || last_inv !== 4'b0000 || last_blk !== 4'b0100 || exp_q.size() != 0) begin
`else
        if (last_val !== 16'h3010 || last_inv !== 4'b0100 || exp_q.size() != 0) begin
`endif
            miscompares++;
            $display("FAIL invalid_digit: value=%h invalid=%b blank=%b, required 3010 with digit 2 flagged",
                     last_val, last_inv, last_blk);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        mon_en    = 1'b0;
        out_ready = 1'b0;
        scan(16'hABCD, 6);
        scan(16'h1234, 6);
        dwell(7'h00, '0, 8);
        vectors++;
        if (out_valid !== 1'b1 || value !== 16'hABCD || invalid !== 4'b0000 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_hold: out_valid=%b value=%h invalid=%b overrun=%b, required 1 ABCD 0000 1",
                     out_valid, value, invalid, overrun);
        end
        out_ready = 1'b1;
        @(negedge clock);
        vectors++;
        if (out_valid !== 1'b0 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_release: out_valid=%b overrun=%b, required 0 1", out_valid, overrun);
        end
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic test_multihot();
        int seen0;
        do_reset();
        seen0 = frames_seen;
        dwell(7'h7E, 4'b0011, 20);
        dwell(7'h00, 4'b0000, 5);
        dwell(7'h6D, 4'b0100, 6);
        dwell(7'h79, 4'b1000, 6);
        dwell(7'h00, '0, 10);
        vectors++;
        if (frames_seen !== seen0) begin
            miscompares++;
            $display("FAIL multihot: frames=%0d, required 0", frames_seen - seen0);
        end
        dwell(7'h7E, 4'b0001, 6);
        dwell(7'h30, 4'b0010, 6);
        dwell(7'h00, '0, 10);
        vectors++;
        if (frames_seen - seen0 !== 1 || last_val !== 16'h3210 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL multihot_recover: frames=%0d value=%h, required 1 3210", frames_seen - seen0, last_val);
        end
    endtask

    task automatic test_mid_reset();
        int seen0;
        do_reset();
        mon_en    = 1'b0;
        out_ready = 1'b0;
        scan(16'h3210, 6);
        dwell(7'h00, '0, 6);
        dwell(7'h77, 4'b0001, 6);
        dwell(7'h1F, 4'b0010, 6);
        dwell(7'h4E, 4'b0100, 6);
        do_reset();
        vectors++;
        if (value !== '0 || invalid !== '0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: value=%h invalid=%b out_valid=%b overrun=%b, required all 0",
                     value, invalid, out_valid, overrun);
        end
        out_ready = 1'b1;
        mon_en    = 1'b1;
        seen0     = frames_seen;
        dwell(7'h3D, 4'b1000, 6);
        dwell(7'h00, '0, 10);
        vectors++;
        if (frames_seen !== seen0) begin
            miscompares++;
            $display("FAIL mid_reset_partial: frames=%0d, required 0", frames_seen - seen0);
        end
        scan(16'hD5E7, 6);
        dwell(7'h00, '0, 10);
        vectors++;
        if (frames_seen - seen0 !== 1 || last_val !== 16'hD5E7 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL mid_reset_rescan: frames=%0d value=%h, required 1 D5E7", frames_seen - seen0, last_val);
        end
    endtask

    task automatic test_random();
        logic [6:0]   seg, prev_seg;
        logic [N-1:0] sel, prev_sel;
        int           seen0;
        do_reset();
        seen0    = frames_seen;
        prev_seg = '0;
        prev_sel = '0;
        for (int n = 0; n < 300; n++) begin
            do begin
                case ($urandom_range(0, 9))
                    0:       sel = '0;
                    1:       sel = N'($urandom);
                    default: sel = N'(1) << $urandom_range(0, N - 1);
                endcase
                seg = ($urandom_range(0, 3) != 0) ? seg_tab[$urandom_range(0, 15)] : 7'($urandom);
            end while (seg == prev_seg && sel == prev_sel);
            dwell(seg, sel, int'($urandom_range(1, 8)));
            prev_seg = seg;
            prev_sel = sel;
        end
        dwell(7'h00, '0, 10);
        vectors++;
        if (exp_q.size() != 0 || overrun !== 1'b0 || frames_seen == seen0) begin
            miscompares++;
            $display("FAIL random: pending=%0d overrun=%b frames=%0d, required 0 0 >0",
                     exp_q.size(), overrun, frames_seen - seen0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_dwell();
        test_invalid();
        test_overrun();
        test_multihot();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation limit reached");
        $fatal(1, "timeout");
    end
endmodule
